secuenciador_filtro: RTL and testbench

SECUENCIADOR_FILTRO -- requirements
Module: secuenciador_filtro

---
 rtl/secuenciador_filtro.sv | 154 +++++++++++++++
 tb/tb_secuenciador_filtro.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/secuenciador_filtro.sv
// FIR sequencer: walks the taps of an external MAC datapath once per input sample.
// Define SECUENCIADOR_CUENTA_PERDIDAS_EN to add a saturating dropped-sample counter output.
module secuenciador_filtro #(
  parameter int unsigned N    = 25,
  parameter int unsigned TAPS = 5,
  parameter int unsigned AW   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          muestra_lista,
  input  logic [N-1:0]  dato_in,
  input  logic [N-1:0]  y_in,
  output logic [N-1:0]  op_x,
  output logic [AW-1:0] coef_addr,
  output logic          acc_clr,
  output logic          acc_en,
  output logic          ban_list,
  output logic [N-1:0]  dato_out,
  output logic          dato_valido,
  output logic          sobrecarga
`ifdef SECUENCIADOR_CUENTA_PERDIDAS_EN
  ,
  output logic [7:0]    cuenta_perdidas
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StCarga,
    StMac,
    StEspera,
    StSalida
  } state_e;

  localparam logic [AW-1:0] KLast = AW'(TAPS - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic [N-1:0]  muestra_q, muestra_d;
  logic [N-1:0]  x_q [TAPS];
  logic [N-1:0]  x_d [TAPS];
  logic [N-1:0]  dato_q, dato_d;
  logic          sobre_q, sobre_d;
  logic          drop;

  // Any strobe outside IDLE is lost; the running frame never sees it.
  assign drop = muestra_lista && (state_q != StIdle);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    muestra_d = muestra_q;
    x_d       = x_q;
    dato_d    = dato_q;
    sobre_d   = sobre_q | drop;
    unique case (state_q)
      StIdle: begin
        if (muestra_lista) begin
          muestra_d = dato_in;
          state_d   = StCarga;
        end
      end
      StCarga: begin
        x_d[0] = muestra_q;
        for (int i = 1; i < int'(TAPS); i++) begin
          x_d[i] = x_q[i-1];
        end
        k_d     = '0;
        state_d = StMac;
      end
      StMac: begin
        if (k_q == KLast) begin
          k_d     = '0;
          state_d = StEspera;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StEspera: state_d = StSalida;
      StSalida: begin
        dato_d  = y_in;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      k_q       <= '0;
      muestra_q <= '0;
      dato_q    <= '0;
      sobre_q   <= 1'b0;
      for (int i = 0; i < int'(TAPS); i++) begin
        x_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      muestra_q <= muestra_d;
      dato_q    <= dato_d;
      sobre_q   <= sobre_d;
      x_q       <= x_d;
    end
  end

  always_comb begin
    op_x        = '0;
    coef_addr   = '0;
    acc_clr     = 1'b0;
    acc_en      = 1'b0;
    ban_list    = 1'b0;
    dato_valido = 1'b0;
    dato_out    = dato_q;
    unique case (state_q)
      StCarga, StEspera: ban_list = 1'b1;
      StMac: begin
        ban_list  = 1'b1;
        acc_en    = 1'b1;
        acc_clr   = (k_q == '0);
        coef_addr = k_q;
        for (int i = 0; i < int'(TAPS); i++) begin
          if (k_q == AW'(i)) op_x = x_q[i];
        end
      end
      // Pass y_in straight through so dato_out is already valid during the pulse.
      StSalida: begin
        dato_valido = 1'b1;
        dato_out    = y_in;
      end
      default: ;
    endcase
  end

  assign sobrecarga = sobre_q;

`ifdef SECUENCIADOR_CUENTA_PERDIDAS_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (drop && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cuenta_perdidas = cnt_q;
`endif

endmodule

// File: tb/tb_secuenciador_filtro.sv
// Scoreboard bench for secuenciador_filtro (TAPS=5): expected results queued at strobe time.
module tb_secuenciador_filtro;
  localparam int N = 25;
  localparam int TAPS = 5;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          muestra_lista;
  logic [N-1:0]  dato_in, y_in;
  logic [N-1:0]  op_x, dato_out;
  logic [AW-1:0] coef_addr;
  logic          acc_clr, acc_en, ban_list, dato_valido, sobrecarga;
`ifdef SECUENCIADOR_CUENTA_PERDIDAS_EN
  logic [7:0]    cuenta_perdidas;
`endif

  secuenciador_filtro #(.N(N), .TAPS(TAPS), .AW(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .muestra_lista  (muestra_lista),
    .dato_in        (dato_in),
    .y_in           (y_in),
    .op_x           (op_x),
    .coef_addr      (coef_addr),
    .acc_clr        (acc_clr),
    .acc_en         (acc_en),
    .ban_list       (ban_list),
    .dato_out       (dato_out),
    .dato_valido    (dato_valido),
    .sobrecarga     (sobrecarga)
`ifdef SECUENCIADOR_CUENTA_PERDIDAS_EN
    ,
    .cuenta_perdidas(cuenta_perdidas)
`endif
  );

  always #5 clk = ~clk;

  int            n_total = 0;
  int            n_bad = 0;
  logic [N-1:0]  exp_q[$];
  logic [N-1:0]  mx[TAPS];
  logic [N-1:0]  last_out;
  logic          exp_ovr;
  int            exp_drops;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_op_x"}, op_x, 0);
    check_eq({tag, "_addr"}, coef_addr, 0);
    check_eq({tag, "_clr"}, acc_clr, 0);
    check_eq({tag, "_en"}, acc_en, 0);
    check_eq({tag, "_ban"}, ban_list, 0);
    check_eq({tag, "_out"}, dato_out, 0);
    check_eq({tag, "_dv"}, dato_valido, 0);
    check_eq({tag, "_ovr"}, sobrecarga, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_zero("rst");
    tick();
    check_zero("rst_hold");
    reset = 1'b0;
    for (int i = 0; i < TAPS; i++) mx[i] = '0;
    last_out  = '0;
    exp_ovr   = 1'b0;
    exp_drops = 0;
    tick();
    check_zero("idle");
  endtask

  // One frame starting now (cycle 0). sa: cycle of an extra strobe, 0 = none.
  task automatic frame(input logic [N-1:0] d, input int sa);
    logic [N-1:0] yv;
    check_eq("c0_ban", ban_list, 0);
    yv = N'($urandom);
    y_in = yv;
    dato_in = d;
    muestra_lista = 1'b1;
    for (int i = TAPS - 1; i > 0; i--) mx[i] = mx[i-1];
    mx[0] = d;
    exp_q.push_back(yv);
    for (int c = 1; c <= 10; c++) begin
      tick();
      muestra_lista = (c == sa);
      if (c == sa) begin
        dato_in = N'($urandom);
        exp_drops++;
      end
      if (c == 9) y_in = N'($urandom);
      if (sa > 0 && c == sa + 1) exp_ovr = 1'b1;
      check_eq("ban", ban_list, (c >= 1 && c <= 7));
      check_eq("acc_en", acc_en, (c >= 2 && c <= 6));
      check_eq("acc_clr", acc_clr, (c == 2));
      check_eq("dv_cycle", dato_valido, (c == 8));
      check_eq("ovr", sobrecarga, exp_ovr);
      if (c >= 2 && c <= 6) begin
        check_eq("addr", coef_addr, c - 2);
        check_eq("op_x", op_x, mx[c-2]);
      end else begin
        check_eq("addr0", coef_addr, 0);
        check_eq("op_x0", op_x, 0);
      end
      if (dato_valido) begin
        if (exp_q.size() == 0) check_eq("dv_no_exp", dato_valido, 0);
        else begin
          last_out = exp_q.pop_front();
          check_eq("dato_out", dato_out, last_out);
        end
      end else begin
        check_eq("hold", dato_out, last_out);
      end
`ifdef SECUENCIADOR_CUENTA_PERDIDAS_EN
      check_eq("cnt", cuenta_perdidas, (exp_drops > 255) ? 255 : exp_drops);
`endif
    end
    check_eq("sb_drain", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    muestra_lista = 1'b0;
    dato_in = '0;
    y_in = '0;
    reset = 1'b0;
    tick();
    do_reset();

    frame(25'h000_4000, 0);
    frame(25'h000_1234, 4);
    frame(25'h1AB_CDEF, 8);
    frame(25'h000_0777, 0);

    // Abort a frame with reset at cycle 5.
    dato_in = 25'h0F0_F0F0;
    muestra_lista = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      muestra_lista = 1'b0;
    end
    check_eq("pre_abort_en", acc_en, 1);
    do_reset();
    for (int c = 0; c < 10; c++) begin
      check_eq("abort_dv", dato_valido, 0);
      check_eq("abort_ban", ban_list, 0);
      tick();
    end

    // Fresh delay line: third frame must read 3,2,1,0,0.
    frame(25'd1, 0);
    frame(25'd2, 0);
    frame(25'd3, 0);
    for (int i = 0; i < 4; i++) frame(N'($urandom), (i == 2) ? 6 : 0);

`ifdef SECUENCIADOR_CUENTA_PERDIDAS_EN
    for (int i = 0; i < 300; i++) frame(N'($urandom), 3);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
